spart_tx: RTL and testbench

Transmit half of the SPART: it decodes processor-side bus writes for the transmit buffer and the 16-bit baud divisor, and serialises bytes onto `txd` as 8N1 frames. It sits directly downstream of the bus driver/testbench processor model, which writes DB low, DB high, then the TX buffer, and polls `tbr`. The receive path and status register read-back live in a sibling block and are out of scope here.

---
 rtl/spart_tx.sv | 131 +++++++++++++
 tb/tb_spart_tx.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/spart_tx.sv
// SPART transmitter: decodes processor writes to the TX buffer and the baud
// divisor, and serialises queued bytes onto txd as 8N1 frames.
module spart_tx #(
  parameter logic [15:0] DB_RESET = 16'd5207
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  input  logic [7:0] databus,
  output logic       tbr,
  output logic       txd
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, next_state;
  logic        wr_term, wr_prev, wr_stb;
  logic        tx_wr;
  logic [15:0] div;
  logic [7:0]  holding;
  logic        holding_full;
  logic [15:0] count;
  logic [2:0]  bit_idx;
  logic [7:0]  shifter, shift_next;
  logic        bit_done;
  logic        load_frame;
  logic        reload;
  logic        txd_next;

  // Strobe only on the first cycle of a write so a held chip select acts once.
  assign wr_term  = iocs & ~iorw;
  assign wr_stb   = wr_term & ~wr_prev;
  assign tx_wr    = wr_stb && (ioaddr == 2'b00);

  assign bit_done   = (count == 16'd0) && (state != IDLE);
  assign load_frame = (next_state == START) && (state != START);
  assign reload     = load_frame || (bit_done && (next_state != IDLE));
  assign tbr        = ~holding_full;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_prev <= 1'b0;
      div     <= DB_RESET;
    end else begin
      wr_prev <= wr_term;
      if (wr_stb && (ioaddr == 2'b10)) div[7:0]  <= databus;
      if (wr_stb && (ioaddr == 2'b11)) div[15:8] <= databus;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      holding_full <= 1'b0;
    end else begin
      if (load_frame)                 holding_full <= 1'b0;
      if (tx_wr && !holding_full)     holding_full <= 1'b1;
    end
  end

  // NOTE: pure datapath registers carry no reset; their contents are only
  // observed once the matching valid flag or state says they were loaded.
  always_ff @(posedge clk) begin
    if (tx_wr && !holding_full) holding <= databus;
    shifter <= shift_next;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (holding_full) next_state = START;
      START:   if (bit_done) next_state = DATA;
      DATA:    if (bit_done && (bit_idx == 3'd7)) next_state = STOP;
      STOP:    if (bit_done) next_state = holding_full ? START : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic: the shifter and the line level for the coming cycle.
  always_comb begin
    shift_next = shifter;
    if (load_frame)
      shift_next = holding;
    else if ((state == DATA) && bit_done)
      shift_next = {1'b0, shifter[7:1]};

    txd_next = 1'b1;
    case (next_state)
      IDLE:    txd_next = 1'b1;
      START:   txd_next = 1'b0;
      DATA:    txd_next = shift_next[0];
      STOP:    txd_next = 1'b1;
      default: txd_next = 1'b1;
    endcase
  end

  // The divisor is only sampled at a bit start, so mid-frame changes wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= 16'd0;
      bit_idx <= 3'd0;
      txd     <= 1'b1;
    end else begin
      txd <= txd_next;
      if (reload)
        count <= div;
      else if (next_state == IDLE)
        count <= 16'd0;
      else
        count <= count - 16'd1;

      if (load_frame || (state == START))
        bit_idx <= 3'd0;
      else if ((state == DATA) && bit_done)
        bit_idx <= bit_idx + 3'd1;
    end
  end

endmodule

// File: tb/tb_spart_tx.sv
// Directed bench for spart_tx: a vector table for register access and one
// frame, plus hand sequences for reset, held strobe, back-to-back and DIV change.
module tb_spart_tx;

  logic       clk;
  logic       rst;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic [7:0] databus;
  logic       tbr;
  logic       txd;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic       iocs;
    logic       iorw;
    logic [1:0] addr;
    logic [7:0] data;
    logic       exp_tbr;
    logic       exp_txd;
  } vec_t;

  vec_t vecs[$];

  spart_tx dut (
    .clk     (clk),
    .rst     (rst),
    .iocs    (iocs),
    .iorw    (iorw),
    .ioaddr  (ioaddr),
    .databus (databus),
    .tbr     (tbr),
    .txd     (txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish, got running, want finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic i, input logic w, input logic [1:0] a,
                     input logic [7:0] d, input logic t, input logic x);
    vec_t v;
    v = '{i, w, a, d, t, x};
    vecs.push_back(v);
  endtask

  // Write, then one idle cycle so the edge detector re-arms; returns #1 after E+1.
  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    iocs = 1'b1; iorw = 1'b0; ioaddr = a; databus = d;
    @(posedge clk); #1;
    iocs = 1'b0;
    @(posedge clk); #1;
  endtask

  // Expected line level c cycles after a start bit begins (1 after the stop bit).
  function automatic logic level_at(input logic [7:0] b, input int bit_clks, input int c);
    int pos;
    pos = c / bit_clks;
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[3'(pos - 1)];
    return 1'b1;
  endfunction

  initial begin
    logic [9:0] lv6d;
    int n;
    logic e;

    rst = 1'b1; iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00; databus = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_tbr", tbr, 1'b1);
    check("reset_txd", txd, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset divisor: start bit lasts 5208 clocks, one clock after the write edge.
    bus_write(2'b00, 8'hFF);
    check("lat_start_txd", txd, 1'b0);
    n = 1;
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #1;
      if (txd !== 1'b0) break;
      n++;
    end
    check("reset_div_bit_clks", n, 5208);

    // Queue a byte, then reset mid-frame: line idles and the queued byte is lost.
    bus_write(2'b00, 8'h00);
    check("queued_tbr", tbr, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midreset_tbr", tbr, 1'b1);
    check("midreset_txd", txd, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (txd === 1'b1 && tbr === 1'b1) n++;
    end
    check("postreset_idle_cycles", n, 20);

    // Vector table: DIV=3, ignored status/read accesses, then frame 0x6D.
    lv6d = 10'b1011011010;
    add(1, 0, 2'b10, 8'h03, 1, 1);
    add(0, 0, 2'b00, 8'h00, 1, 1);
    add(1, 0, 2'b11, 8'h00, 1, 1);
    add(0, 0, 2'b00, 8'h00, 1, 1);
    add(1, 0, 2'b01, 8'hFF, 1, 1);
    add(0, 0, 2'b00, 8'h00, 1, 1);
    add(1, 1, 2'b10, 8'h00, 1, 1);
    add(0, 0, 2'b00, 8'h00, 1, 1);
    add(1, 1, 2'b00, 8'h99, 1, 1);
    add(0, 0, 2'b00, 8'h00, 1, 1);
    add(1, 1, 2'b11, 8'hFF, 1, 1);
    add(0, 0, 2'b00, 8'h00, 1, 1);
    add(1, 0, 2'b00, 8'h6D, 0, 1);
    for (int i = 0; i < 40; i++) add(0, 0, 2'b00, 8'h00, 1, lv6d[i / 4]);
    for (int i = 0; i < 4; i++)  add(0, 0, 2'b00, 8'h00, 1, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      iocs = vecs[i].iocs; iorw = vecs[i].iorw;
      ioaddr = vecs[i].addr; databus = vecs[i].data;
      @(posedge clk); #1;
      check($sformatf("vec%0d_tbr", i), tbr, vecs[i].exp_tbr);
      check($sformatf("vec%0d_txd", i), txd, vecs[i].exp_txd);
    end

    // Chip select held for 15 edges: exactly one 0xA5 frame.
    iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b00; databus = 8'hA5;
    @(posedge clk); #1;
    check("held_tbr", tbr, 1'b0);
    for (int c = 0; c < 48; c++) begin
      @(posedge clk); #1;
      if (c == 13) iocs = 1'b0;
      check($sformatf("held_txd[%0d]", c), txd, level_at(8'hA5, 4, c));
    end
    check("held_end_tbr", tbr, 1'b1);

    // DIV 3 -> 7 written during data bit 3 of 0x33; later bits stretch to 8 clocks.
    bus_write(2'b00, 8'h33);
    for (int c = 0; c < 66; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      // After cycle 20 the frame continues from position 5 at 8 clocks per bit.
      e = (c < 20) ? level_at(8'h33, 4, c) : level_at(8'h33, 8, c + 20);
      check($sformatf("divchg_txd[%0d]", c), txd, e);
      if (c == 16) begin
        iocs = 1'b1; ioaddr = 2'b10; databus = 8'h07;
      end
      if (c == 17) iocs = 1'b0;
    end

    // DIV=1: 0x55 then queued 0xF0 back to back; 0x12 written while full is dropped.
    bus_write(2'b10, 8'h01);
    bus_write(2'b00, 8'h55);
    for (int c = 0; c < 46; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      e = (c < 20) ? level_at(8'h55, 2, c) : level_at(8'hF0, 2, c - 20);
      check($sformatf("b2b_txd[%0d]", c), txd, e);
      check($sformatf("b2b_tbr[%0d]", c), tbr, (c >= 1 && c < 20) ? 1'b0 : 1'b1);
      if (c == 0) begin
        iocs = 1'b1; ioaddr = 2'b00; databus = 8'hF0;
      end
      if (c == 1) iocs = 1'b0;
      if (c == 3) begin
        iocs = 1'b1; ioaddr = 2'b00; databus = 8'h12;
      end
      if (c == 4) iocs = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
